beam_pair_detector: RTL and testbench

//   Front-end that produces the single-cycle human_detected pulse consumed by the occupancy counter.

---
 rtl/beam_pkg.sv | 18 +
 rtl/beam_debounce.sv | 42 ++++
 rtl/beam_pair_detector.sv | 128 ++++++++++++
 tb/tb_beam_pair_detector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/beam_pkg.sv
// Shared types and constants for the doorway break-beam pair detector.
package beam_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      E_A   = 3'd1,
      E_AB  = 3'd2,
      E_B   = 3'd3,
      X_B   = 3'd4,
      X_BA  = 3'd5,
      X_A   = 3'd6,
      STUCK = 3'd7
   } state_t;

   localparam int unsigned BEAM_A = 0;
   localparam int unsigned BEAM_B = 1;

endpackage

// File: rtl/beam_debounce.sv
// Two-flop synchroniser followed by a stability filter for one IR beam.
module beam_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_in,
   output logic filt_out
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync_q1;
   logic          sync_q2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw_in;
         sync_q2 <= sync_q1;
      end
   end

   // Counter tracks consecutive disagreeing cycles; the level flips on the Nth one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         filt_out <= 1'b0;
      end else if (sync_q2 == filt_out) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
         cnt      <= '0;
         filt_out <= sync_q2;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/beam_pair_detector.sv
// Decodes the order of two debounced doorway beams into entry/exit pulses
// and raises a fault when a beam or sequence stays active too long.
module beam_pair_detector
   import beam_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       beam_a_raw,
   input  logic       beam_b_raw,
   input  logic       enable,
   output logic       human_detected,
   output logic       human_exited,
   output logic       fault,
   output logic [1:0] beams_filt
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t        state;
   state_t        state_next;
   logic [TW-1:0] tcnt;
   logic [TW-1:0] tcnt_next;
   logic [1:0]    ab;
   logic          active_c;
   logic          timeout_c;
   logic          detect_c;
   logic          exit_c;

   beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk      (clk),
      .reset    (reset),
      .raw_in   (beam_a_raw),
      .filt_out (beams_filt[BEAM_A])
   );

   beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk      (clk),
      .reset    (reset),
      .raw_in   (beam_b_raw),
      .filt_out (beams_filt[BEAM_B])
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         tcnt           <= '0;
         human_detected <= 1'b0;
         human_exited   <= 1'b0;
         fault          <= 1'b0;
      end else begin
         state          <= state_next;
         tcnt           <= tcnt_next;
         human_detected <= detect_c;
         human_exited   <= exit_c;
         fault          <= (state_next == STUCK);
      end
   end

   // Timeout only arms while something is active, so a fresh IDLE after STUCK
   // does not immediately re-trip on the still-saturated count.
   always_comb begin
      state_next = state;
      tcnt_next  = '0;
      detect_c   = 1'b0;
      exit_c     = 1'b0;
      ab         = {beams_filt[BEAM_A], beams_filt[BEAM_B]};
      active_c   = (|beams_filt) || (state != IDLE);
      timeout_c  = active_c && (tcnt == TW'(TIMEOUT_CYCLES)) && (state != STUCK);

      if (!enable) begin
         state_next = IDLE;
      end else begin
         if (active_c) begin
            tcnt_next = (tcnt == TW'(TIMEOUT_CYCLES)) ? tcnt : tcnt + TW'(1);
         end
         if (timeout_c) begin
            state_next = STUCK;
         end else begin
            case (state)
               IDLE: begin
                  if (ab == 2'b10)      state_next = E_A;
                  else if (ab == 2'b01) state_next = X_B;
               end
               E_A: begin
                  if (ab == 2'b00)      state_next = IDLE;
                  else if (ab == 2'b11) state_next = E_AB;
               end
               E_AB: begin
                  if (ab == 2'b10)      state_next = E_A;
                  else if (ab == 2'b01) state_next = E_B;
               end
               E_B: begin
                  if (ab == 2'b00) begin
                     state_next = IDLE;
                     detect_c   = 1'b1;
                  end else if (ab == 2'b11) begin
                     state_next = E_AB;
                  end
               end
               X_B: begin
                  if (ab == 2'b00)      state_next = IDLE;
                  else if (ab == 2'b11) state_next = X_BA;
               end
               X_BA: begin
                  if (ab == 2'b01)      state_next = X_B;
                  else if (ab == 2'b10) state_next = X_A;
               end
               X_A: begin
                  if (ab == 2'b00) begin
                     state_next = IDLE;
                     exit_c     = 1'b1;
                  end else if (ab == 2'b11) begin
                     state_next = X_BA;
                  end
               end
               STUCK: begin
                  if (ab == 2'b00) state_next = IDLE;
               end
               default: state_next = IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_beam_pair_detector.sv
// Self-checking bench for beam_pair_detector: vector table plus pulse scoreboard.
module tb_beam_pair_detector;

   localparam int unsigned DEB = 4;
   localparam int unsigned TMO = 64;
   localparam int          LAT = DEB + 3;

   logic       clk;
   logic       reset;
   logic       beam_a_raw;
   logic       beam_b_raw;
   logic       enable;
   logic       human_detected;
   logic       human_exited;
   logic       fault;
   logic [1:0] beams_filt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic       a;
      logic       b;
      logic       en;
      logic       det;
      logic       ext;
      logic [1:0] filt;
   } step_t;

   typedef struct {
      logic [1:0] kind;
      int         cyc;
   } exp_t;

   step_t steps[$];
   exp_t  exp_q[$];

   beam_pair_detector #(
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .beam_a_raw     (beam_a_raw),
      .beam_b_raw     (beam_b_raw),
      .enable         (enable),
      .human_detected (human_detected),
      .human_exited   (human_exited),
      .fault          (fault),
      .beams_filt     (beams_filt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every output pulse must match the oldest expected pulse in kind and cycle.
   always @(negedge clk) begin
      if (human_detected || human_exited) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse det=%0b exit=%0b cycle=%0d, required no pulse",
                     human_detected, human_exited, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.kind !== {human_exited, human_detected} || e.cyc != cyc) begin
               errors++;
               $display("FAIL pulse got {exit,det}=%b at cycle %0d, required %b at cycle %0d",
                        {human_exited, human_detected}, cyc, e.kind, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h required %0h", name, act, req);
      end
   endtask

   task automatic add(input logic a, input logic b, input logic en,
                      input logic det, input logic ext, input logic [1:0] filt);
      step_t s;
      s.a = a; s.b = b; s.en = en; s.det = det; s.ext = ext; s.filt = filt;
      steps.push_back(s);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic a, input logic b);
      exp_t e;
      beam_a_raw = a;
      beam_b_raw = b;
      e.cyc = cyc;
   endtask

   initial begin
      int   t0;
      int   tf;
      bit   seen;

      reset      = 1'b1;
      beam_a_raw = 1'b0;
      beam_b_raw = 1'b0;
      enable     = 1'b1;
      tick(3);
      check("reset_detected", 32'(human_detected), 32'd0);
      check("reset_exited",   32'(human_exited),   32'd0);
      check("reset_fault",    32'(fault),          32'd0);
      check("reset_filt",     32'(beams_filt),     32'd0);
      reset = 1'b0;
      tick(2);

      // entry A, AB, B, none
      add(1, 0, 1, 0, 0, 2'b01); add(1, 1, 1, 0, 0, 2'b11);
      add(0, 1, 1, 0, 0, 2'b10); add(0, 0, 1, 1, 0, 2'b00);
      // exit B, BA, A, none
      add(0, 1, 1, 0, 0, 2'b10); add(1, 1, 1, 0, 0, 2'b11);
      add(1, 0, 1, 0, 0, 2'b01); add(0, 0, 1, 0, 1, 2'b00);
      // reversed entry A, AB, A, none
      add(1, 0, 1, 0, 0, 2'b01); add(1, 1, 1, 0, 0, 2'b11);
      add(1, 0, 1, 0, 0, 2'b01); add(0, 0, 1, 0, 0, 2'b00);
      // backed-out exit, then simultaneous arrival
      add(0, 1, 1, 0, 0, 2'b10); add(0, 0, 1, 0, 0, 2'b00);
      add(1, 1, 1, 0, 0, 2'b11); add(0, 0, 1, 0, 0, 2'b00);
      // full entry while disabled, then enabled entry
      add(1, 0, 0, 0, 0, 2'b01); add(1, 1, 0, 0, 0, 2'b11);
      add(0, 1, 0, 0, 0, 2'b10); add(0, 0, 0, 0, 0, 2'b00);
      add(1, 0, 1, 0, 0, 2'b01); add(1, 1, 1, 0, 0, 2'b11);
      add(0, 1, 1, 0, 0, 2'b10); add(0, 0, 1, 1, 0, 2'b00);

      foreach (steps[i]) begin
         exp_t e;
         beam_a_raw = steps[i].a;
         beam_b_raw = steps[i].b;
         enable     = steps[i].en;
         e.cyc      = cyc + LAT;
         if (steps[i].det) begin
            e.kind = 2'b01;
            exp_q.push_back(e);
         end
         if (steps[i].ext) begin
            e.kind = 2'b10;
            exp_q.push_back(e);
         end
         tick(10);
         check($sformatf("step%0d_filt", i), 32'(beams_filt), 32'(steps[i].filt));
         check($sformatf("step%0d_fault", i), 32'(fault), 32'd0);
      end
      enable = 1'b1;

      // short glitches on A never pass the filter
      for (int g = 0; g < 20; g++) begin
         beam_a_raw = 1'b1;
         tick(3);
         beam_a_raw = 1'b0;
         tick(3);
         check($sformatf("glitch%0d_filt", g), 32'(beams_filt), 32'd0);
      end
      tick(8);
      check("glitch_fault", 32'(fault), 32'd0);

      // A held blocked long enough to time out
      beam_a_raw = 1'b1;
      t0   = cyc;
      tf   = 0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (fault && !seen) begin
            seen = 1'b1;
            tf   = cyc;
         end
      end
      check("timeout_seen", 32'(seen), 32'd1);
      check("timeout_rise_in_window",
            32'((tf >= t0 + LAT + int'(TMO) - 1) && (tf <= t0 + LAT + int'(TMO) + 1)), 32'd1);
      check("timeout_held", 32'(fault), 32'd1);
      beam_a_raw = 1'b0;
      tick(12);
      check("timeout_release_fault", 32'(fault), 32'd0);
      check("timeout_release_filt", 32'(beams_filt), 32'd0);
      tick(5);
      check("timeout_no_refault", 32'(fault), 32'd0);

      // reset asserted while in E_B discards the sequence
      beam_a_raw = 1'b1; tick(10);
      beam_b_raw = 1'b1; tick(10);
      beam_a_raw = 1'b0; tick(10);
      check("pre_reset_filt", 32'(beams_filt), 32'b10);
      #2 reset = 1'b1;
      #1;
      check("midreset_detected", 32'(human_detected), 32'd0);
      check("midreset_exited",   32'(human_exited),   32'd0);
      check("midreset_fault",    32'(fault),          32'd0);
      check("midreset_filt",     32'(beams_filt),     32'd0);
      tick(2);
      reset = 1'b0;
      tick(10);
      beam_b_raw = 1'b0;
      tick(12);
      check("post_reset_filt", 32'(beams_filt), 32'd0);
      check("post_reset_fault", 32'(fault), 32'd0);

      tick(5);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
